// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill / write-back engine.
// Holds the controller state encoding, the default line size and the fixed
// memory-burst attributes (4-byte beats, incrementing bursts).
package icache_refill_pkg;

    // Controller states. IDLE must stay encoding 0 so a cleared register is idle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } refill_state_e;

    // Words per cache line, which is also the beat count of one burst.
    localparam int LINE_WORDS = 16;

    // Fixed burst attributes: every beat is one 32-bit word, addresses increment.
    localparam logic [2:0] BURST_SIZE_4B   = 3'b010;
    localparam logic [1:0] BURST_TYPE_INCR = 2'b01;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line transfer engine.
//
// Accepts one line request at a time from the cache and turns it into either
// a read burst (refill) or a write burst (write-back) on the memory side.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   sen, wen, addr, wdata    : cache request (wen=1 write-back), write-back word
//   addr_ok                  : request accepted (combinational, IDLE only)
//   data_ok, sdata, burst    : one beat moved; refill word; last beat of line
//   araddr..rready           : memory read address / data channels
//   awaddr..bready           : memory write address / data / response channels
//   err                      : sticky flag, rlast seen on the wrong beat
//
// All cache-side handshakes are combinational from the current state and the
// memory-side valid/ready inputs, so a beat is reported in the same cycle it
// crosses the memory interface.
module icache_refill #(
    parameter int LINE_WORDS = icache_refill_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    // cache side
    input  logic              sen,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       sdata,
    output logic              burst,
    // memory read side
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    // memory write side
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata_m,
    output logic              wvalid,
    output logic              wlast,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    // status
    output logic              err
);
    import icache_refill_pkg::*;

    localparam int              CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]      BURST_LEN = 8'(LINE_WORDS - 1);

    refill_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = err_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        sdata     = '0;
        burst     = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awaddr    = '0;
        awlen     = '0;
        awvalid   = 1'b0;
        wdata_m   = '0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        last_beat = (cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (sen) begin
                    addr_ok = 1'b1;
                    addr_d  = addr;
                    state_d = wen ? WADDR : RADDR;
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                arlen   = BURST_LEN;
                if (arready) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_ok = 1'b1;
                    sdata   = rdata;
                    burst   = last_beat;
                    cnt_d   = cnt_q + 1'b1;
                    // The beat count alone ends the burst; a misplaced rlast is
                    // only recorded, never acted on.
                    if (rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            WADDR: begin
                awvalid = 1'b1;
                awaddr  = addr_q;
                awlen   = BURST_LEN;
                if (awready) begin
                    cnt_d   = '0;
                    state_d = WDATA;
                end
            end
            WDATA: begin
                wvalid  = 1'b1;
                wdata_m = wdata;
                wlast   = last_beat;
                // data_ok tells the cache to advance to its next word.
                if (wready) begin
                    data_ok = 1'b1;
                    burst   = last_beat;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err = err_q;

endmodule
